// File: rtl/alu_seq_pkg.sv
// Shared encodings for the ALU issue sequencer: instruction classes, ALU
// op codes, branch conditions, flag bit positions and the FSM state type.
package alu_seq_pkg;

  // Instruction class field [31:29]; any class with bit 2 set is illegal
  localparam logic [2:0] CLS_REG = 3'b000;
  localparam logic [2:0] CLS_IMM = 3'b001;
  localparam logic [2:0] CLS_BR  = 3'b010;
  localparam logic [2:0] CLS_NOP = 3'b011;

  // ALU operation codes, alu_control[2:0]
  localparam logic [2:0] OP_DIFF = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_NEG  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SLL  = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  // alu_control[3] selects the shamt/immediate as ALU in2
  localparam int CTRL_IMM_BIT = 3;

  // Branches use add so the ALU carry reflects rs+rt
  localparam logic [3:0] CTRL_BR_ADD = {1'b0, OP_ADD};
  localparam logic [3:0] CTRL_NONE   = 4'b0000;

  // Branch condition codes, instruction field [28:26]
  localparam logic [2:0] COND_Z      = 3'b000;
  localparam logic [2:0] COND_NZ     = 3'b001;
  localparam logic [2:0] COND_NEG    = 3'b010;
  localparam logic [2:0] COND_POS    = 3'b011;
  localparam logic [2:0] COND_CY     = 3'b100;
  localparam logic [2:0] COND_NC     = 3'b101;
  localparam logic [2:0] COND_ALWAYS = 3'b110;
  localparam logic [2:0] COND_ILL    = 3'b111;

  // ALU flag bit positions
  localparam int FLAG_CY = 0;
  localparam int FLAG_Z  = 1;
  localparam int FLAG_N  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_FLAG = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // ALU control word for a given class/op; classes that do not use the ALU get zero
  function automatic logic [3:0] alu_ctrl_f(input logic [2:0] cls, input logic [2:0] op);
    logic [3:0] ctrl;
    ctrl = CTRL_NONE;
    case (cls)
      CLS_REG: ctrl = {1'b0, op};
      CLS_IMM: begin
        ctrl = {1'b0, op};
        ctrl[CTRL_IMM_BIT] = 1'b1;
      end
      CLS_BR:  ctrl = CTRL_BR_ADD;
      default: ctrl = CTRL_NONE;
    endcase
    return ctrl;
  endfunction

  // True for classes that present operands to the ALU
  function automatic logic alu_used_f(input logic [2:0] cls);
    logic used;
    case (cls)
      CLS_REG, CLS_IMM, CLS_BR: used = 1'b1;
      default:                  used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/alu_sequencer_branch_eval.sv
// Combinational branch condition evaluation against the captured ALU flags.
module alu_branch_eval
  import alu_seq_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken,
  output logic       cond_illegal
);

  // Decode the condition code into a taken decision or an illegal indication
  always_comb begin
    taken        = 1'b0;
    cond_illegal = 1'b0;
    case (cond)
      COND_Z:      taken = flags[FLAG_Z];
      COND_NZ:     taken = ~flags[FLAG_Z];
      COND_NEG:    taken = flags[FLAG_N];
      COND_POS:    taken = ~flags[FLAG_Z] & ~flags[FLAG_N];
      COND_CY:     taken = flags[FLAG_CY];
      COND_NC:     taken = ~flags[FLAG_CY];
      COND_ALWAYS: taken = 1'b1;
      default: begin
        taken        = 1'b0;
        cond_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU issue/control unit. One instruction per four cycles:
// IDLE (accept) -> EXEC (operands to ALU) -> FLAG (hold, capture result)
// -> DONE (writeback / branch / illegal strobe). All outputs registered.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int SHAMT_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [3:0]         alu_control,
  output logic [SHAMT_W-1:0] alu_shamt,
  output logic [REG_AW-1:0]  rs_addr,
  output logic [REG_AW-1:0]  rt_addr,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [2:0]         alu_flag,
  output logic               wb_en,
  output logic [REG_AW-1:0]  wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               br_taken,
  output logic [DATA_W-1:0]  br_offset,
  output logic               illegal,
  output logic               busy
);

  state_t            state_r;
  logic [2:0]        cls_r;
  logic [2:0]        op_r;
  logic [REG_AW-1:0] rd_r;
  logic [9:0]        imm_r;

  logic [3:0]        ctrl_s;
  logic              alu_used_s;
  logic              accept_s;
  logic              taken_s;
  logic              cond_illegal_s;
  logic              unused_instr_s;

  // Bit 10 of the instruction word carries no meaning
  assign unused_instr_s = instr[10];

  assign accept_s = instr_valid & instr_ready;

  // Decode the offered instruction so ALU-side outputs are valid throughout EXEC
  always_comb begin
    ctrl_s     = alu_ctrl_f(instr[31:29], instr[28:26]);
    alu_used_s = alu_used_f(instr[31:29]);
  end

  // Branch decision uses the live flags at the end of FLAG, i.e. the carry
  // registered by the ALU at the EXEC->FLAG edge
  alu_branch_eval u_branch_eval (
    .cond         (op_r),
    .flags        (alu_flag),
    .taken        (taken_s),
    .cond_illegal (cond_illegal_s)
  );

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cls_r       <= 3'b000;
      op_r        <= 3'b000;
      rd_r        <= {REG_AW{1'b0}};
      imm_r       <= 10'd0;
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      alu_control <= 4'b0000;
      alu_shamt   <= {SHAMT_W{1'b0}};
      rs_addr     <= {REG_AW{1'b0}};
      rt_addr     <= {REG_AW{1'b0}};
      wb_en       <= 1'b0;
      wb_addr     <= {REG_AW{1'b0}};
      wb_data     <= {DATA_W{1'b0}};
      br_taken    <= 1'b0;
      br_offset   <= {DATA_W{1'b0}};
      illegal     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          wb_en    <= 1'b0;
          br_taken <= 1'b0;
          illegal  <= 1'b0;
          if (accept_s) begin
            state_r     <= ST_EXEC;
            cls_r       <= instr[31:29];
            op_r        <= instr[28:26];
            rd_r        <= REG_AW'(instr[15:11]);
            imm_r       <= instr[9:0];
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            alu_control <= ctrl_s;
            if (alu_used_s) begin
              alu_shamt <= SHAMT_W'(instr[9:0]);
              rs_addr   <= REG_AW'(instr[25:21]);
              rt_addr   <= REG_AW'(instr[20:16]);
            end else begin
              alu_shamt <= {SHAMT_W{1'b0}};
              rs_addr   <= {REG_AW{1'b0}};
              rt_addr   <= {REG_AW{1'b0}};
            end
          end else begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
          end
        end

        ST_EXEC: begin
          state_r <= ST_FLAG;
        end

        ST_FLAG: begin
          state_r     <= ST_DONE;
          alu_control <= 4'b0000;
          alu_shamt   <= {SHAMT_W{1'b0}};
          rs_addr     <= {REG_AW{1'b0}};
          rt_addr     <= {REG_AW{1'b0}};
          wb_data     <= alu_out;
          wb_addr     <= rd_r;
          br_offset   <= {{(DATA_W-10){imm_r[9]}}, imm_r};
          case (cls_r)
            CLS_REG, CLS_IMM: begin
              wb_en    <= (rd_r != {REG_AW{1'b0}});
              br_taken <= 1'b0;
              illegal  <= 1'b0;
            end
            CLS_BR: begin
              wb_en    <= 1'b0;
              br_taken <= taken_s & ~cond_illegal_s;
              illegal  <= cond_illegal_s;
            end
            CLS_NOP: begin
              wb_en    <= 1'b0;
              br_taken <= 1'b0;
              illegal  <= 1'b0;
            end
            default: begin
              wb_en    <= 1'b0;
              br_taken <= 1'b0;
              illegal  <= 1'b1;
            end
          endcase
        end

        ST_DONE: begin
          state_r     <= ST_IDLE;
          wb_en       <= 1'b0;
          br_taken    <= 1'b0;
          illegal     <= 1'b0;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          instr_ready <= 1'b0;
          busy        <= 1'b0;
          alu_control <= 4'b0000;
          alu_shamt   <= {SHAMT_W{1'b0}};
          rs_addr     <= {REG_AW{1'b0}};
          rt_addr     <= {REG_AW{1'b0}};
          wb_en       <= 1'b0;
          br_taken    <= 1'b0;
          illegal     <= 1'b0;
        end
      endcase
    end
  end

endmodule
